// File: rtl/inst_mem_loader.sv
// Writable instruction memory filled by a byte-serial boot loader, which holds the CPU in reset until the image is complete.
// Fetch data is combinational (zero latency). Loader bytes are taken whenever byte_ready is high; there is no other backpressure.
module inst_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        cpu_rst_o,
    output logic        loaded_o,
    output logic        err_o,
    output logic [15:0] words_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_RUN
    } state_t;

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_len;
    logic [ADDR_W-1:0]   r_widx;
    logic [1:0]          r_bidx;
    logic [23:0]         r_shift;
    logic                r_err;
    logic [15:0]         r_words;
    logic                r_cpu_rst;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic                w_accept;
    logic [15:0]         w_len_full;
    logic                w_len_zero;
    logic                w_len_big;
    logic                w_last_byte;
    logic                w_last_word;
    logic                w_addr_in_range;
    logic                w_unused_addr_lsb;

    assign w_accept    = byte_ready & byte_valid;
    assign w_len_full  = {r_len[15:8], byte_data};
    assign w_len_zero  = (w_len_full == 16'd0);
    assign w_len_big   = ({1'b0, w_len_full} > DEPTH);
    assign w_last_byte = (r_state == S_DATA) && w_accept && (r_bidx == 2'd3);
    assign w_last_word = (16'(r_widx) == (r_len - 16'd1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (load_start) w_next = S_LEN_HI;
            S_LEN_HI: if (w_accept)   w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_zero)     w_next = S_RUN;
                    else if (w_len_big) w_next = S_IDLE;
                    else                w_next = S_DATA;
                end
            end
            S_DATA:   if (w_last_byte && w_last_word) w_next = S_RUN;
            S_RUN:    if (load_start) w_next = S_LEN_HI;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        byte_ready = 1'b0;
        loaded_o   = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA: byte_ready = 1'b1;
            S_RUN:                      loaded_o   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_widx    <= '0;
            r_bidx    <= '0;
            r_shift   <= '0;
            r_err     <= 1'b0;
            r_words   <= '0;
            r_cpu_rst <= 1'b1;
        end else begin
            // Looking at next state lets the CPU leave reset in the first RUN cycle.
            r_cpu_rst <= (w_next != S_RUN);
            case (r_state)
                S_LEN_HI: if (w_accept) r_len[15:8] <= byte_data;
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= byte_data;
                        if (w_len_zero) begin
                            r_words <= '0;
                            r_err   <= 1'b0;
                        end else if (w_len_big) begin
                            r_err   <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_widx  <= '0;
                            r_bidx  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_bidx  <= r_bidx + 2'd1;
                        r_shift <= {r_shift[15:0], byte_data};
                        if (r_bidx == 2'd3) begin
                            r_widx <= r_widx + ADDR_W'(1);
                            if (w_last_word) r_words <= r_len;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_last_byte) r_mem[r_widx] <= {r_shift, byte_data};
    end

    assign w_addr_in_range   = (rom_addr_i[31:ADDR_W+2] == '0);
    assign w_unused_addr_lsb = ^rom_addr_i[1:0];
    assign rom_data_o = (rom_ce_i && loaded_o && w_addr_in_range) ?
                        r_mem[rom_addr_i[ADDR_W+1:2]] : 32'd0;

    assign cpu_rst_o = r_cpu_rst;
    assign err_o     = r_err;
    assign words_o   = r_words;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: table-driven fetch vectors plus hand-written load sequences.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        cpu_rst_o;
    logic        loaded_o;
    logic        err_o;
    logic [15:0] words_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          grp;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } fvec_t;

    fvec_t tbl[$];

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_rst_o  (cpu_rst_o),
        .loaded_o   (loaded_o),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        chk("byte_ready_at_send", 32'(byte_ready), 32'd1);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        send(v[31:24], gap);
        send(v[23:16], gap);
        send(v[15:8], gap);
        send(v[7:0], gap);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic fetch(input string name, input logic ce, input logic [31:0] addr,
                         input logic [31:0] exp);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
        chk(name, rom_data_o, exp);
    endtask

    task automatic run_table(input int g);
        foreach (tbl[i]) begin
            if (tbl[i].grp == g)
                fetch($sformatf("tbl%0d_grp%0d", i, g), tbl[i].ce, tbl[i].addr, tbl[i].exp);
        end
        rom_ce_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img_b [12];

        // Image A: 3401000A, 0000000C
        tbl.push_back('{1, 1'b1, 32'h0000_0000, 32'h3401_000A});
        tbl.push_back('{1, 1'b1, 32'h0000_0004, 32'h0000_000C});
        tbl.push_back('{1, 1'b1, 32'h0000_0006, 32'h0000_000C});
        tbl.push_back('{1, 1'b1, 32'h0000_0003, 32'h3401_000A});
        tbl.push_back('{1, 1'b0, 32'h0000_0004, 32'h0000_0000});
        tbl.push_back('{1, 1'b1, 32'h0000_1000, 32'h0000_0000});
        tbl.push_back('{1, 1'b1, 32'h8000_0004, 32'h0000_0000});
        // Image B: DEADBEEF, 01234567
        tbl.push_back('{2, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF});
        tbl.push_back('{2, 1'b1, 32'h0000_0005, 32'h0123_4567});
        tbl.push_back('{2, 1'b0, 32'h0000_0000, 32'h0000_0000});
        // Full-depth image: word i = C0DE0000 | i
        tbl.push_back('{3, 1'b1, 32'h0000_0000, 32'hC0DE_0000});
        tbl.push_back('{3, 1'b1, 32'h0000_0004, 32'hC0DE_0001});
        tbl.push_back('{3, 1'b1, 32'h0000_0800, 32'hC0DE_0200});
        tbl.push_back('{3, 1'b1, 32'h0000_0FFC, 32'hC0DE_03FF});
        tbl.push_back('{3, 1'b1, 32'h0000_0FFF, 32'hC0DE_03FF});
        tbl.push_back('{3, 1'b1, 32'h0000_1000, 32'h0000_0000});
        tbl.push_back('{3, 1'b1, 32'h0000_1FFC, 32'h0000_0000});
        // One-word reload after an aborted load
        tbl.push_back('{4, 1'b1, 32'h0000_0000, 32'h9988_7766});
        tbl.push_back('{4, 1'b1, 32'h0000_0004, 32'hC0DE_0001});
        tbl.push_back('{4, 1'b1, 32'h0000_0FFC, 32'hC0DE_03FF});

        img_b = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00};

        rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0;
        load_start = 1'b0; byte_valid = 1'b0; byte_data = '0;
        step();
        rst = 1'b0;
        chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rst_loaded", 32'(loaded_o), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_words", 32'(words_o), 32'd0);
        fetch("rst_fetch0", 1'b1, 32'h0, 32'h0);
        fetch("rst_fetch4", 1'b1, 32'h4, 32'h0);
        rom_ce_i = 1'b0;

        // Image A, back-to-back bytes
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send_word(32'h3401_000A, 1'b0);
        chk("a_not_loaded_before_last", 32'(loaded_o), 32'd0);
        send_word(32'h0000_000C, 1'b0);
        chk("a_loaded", 32'(loaded_o), 32'd1);
        chk("a_cpu_rst", 32'(cpu_rst_o), 32'd0);
        chk("a_words", 32'(words_o), 32'd2);
        chk("a_byte_ready_run", 32'(byte_ready), 32'd0);
        run_table(1);

        // Reload from RUN: CPU reset reasserts and fetches go dark
        pulse_start();
        chk("reload_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("reload_loaded", 32'(loaded_o), 32'd0);
        fetch("reload_fetch", 1'b1, 32'h0, 32'h0);
        rom_ce_i = 1'b0;

        // Image B with valid toggling and a stray load_start mid-DATA
        for (int i = 0; i < 10; i++) begin
            if (i == 4) load_start = 1'b1;
            send(img_b[i], 1'b1);
            load_start = 1'b0;
        end
        chk("b_loaded", 32'(loaded_o), 32'd1);
        chk("b_words", 32'(words_o), 32'd2);
        run_table(2);

        // Zero length goes straight to RUN
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("z_loaded", 32'(loaded_o), 32'd1);
        chk("z_cpu_rst", 32'(cpu_rst_o), 32'd0);
        chk("z_words", 32'(words_o), 32'd0);
        fetch("z_fetch_old", 1'b1, 32'h0, 32'hDEAD_BEEF);
        rom_ce_i = 1'b0;

        // Oversize length rejected
        pulse_start();
        send(8'h04, 1'b0);
        send(8'h01, 1'b0);
        chk("big_err", 32'(err_o), 32'd1);
        chk("big_loaded", 32'(loaded_o), 32'd0);
        chk("big_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("big_byte_ready", 32'(byte_ready), 32'd0);
        chk("big_words", 32'(words_o), 32'd0);
        step();
        chk("big_cpu_rst_held", 32'(cpu_rst_o), 32'd1);

        // Exactly full depth is accepted and clears err
        pulse_start();
        send(8'h04, 1'b0);
        send(8'h00, 1'b0);
        chk("full_err_cleared", 32'(err_o), 32'd0);
        for (int i = 0; i < 1024; i++) begin
            send_word(32'hC0DE_0000 | 32'(i), 1'b0);
        end
        chk("full_loaded", 32'(loaded_o), 32'd1);
        chk("full_words", 32'(words_o), 32'h400);
        run_table(3);

        // rst beats load_start
        rst = 1'b1; load_start = 1'b1;
        step();
        rst = 1'b0; load_start = 1'b0;
        chk("rs_loaded", 32'(loaded_o), 32'd0);
        chk("rs_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rs_byte_ready", 32'(byte_ready), 32'd0);
        chk("rs_words", 32'(words_o), 32'd0);
        step();
        chk("rs_still_idle", 32'(byte_ready), 32'd0);

        // Reset after 5 data bytes aborts the load
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send(8'h55, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_loaded", 32'(loaded_o), 32'd0);
        chk("abort_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("abort_byte_ready", 32'(byte_ready), 32'd0);
        fetch("abort_fetch", 1'b1, 32'h0, 32'h0);
        rom_ce_i = 1'b0;

        // Fresh one-word load after the abort
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send_word(32'h9988_7766, 1'b0);
        chk("fresh_loaded", 32'(loaded_o), 32'd1);
        chk("fresh_words", 32'(words_o), 32'd1);
        run_table(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
